// File: rtl/tomasulo_core.sv
// Tomasulo/ROB schedule generator: loads a short program, then replays
// issue/execute/CDB/commit one simulated cycle per clock into event tables.
module tomasulo_core #(
   parameter int NUM_INSTRUCTIONS  = 8,
   parameter int NUM_REGISTERS     = 8,
   parameter int INSTR_WIDTH       = 3,
   parameter int NUM_CYCLES        = 128,
   parameter int CYCLE_WIDTH       = 8,
   parameter int INSTRUCTION_WIDTH = 11
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [INSTRUCTION_WIDTH-1:0]            instruction,
   input  logic                                    load_instruction,
   input  logic                                    loading_complete,
   output logic [NUM_INSTRUCTIONS*CYCLE_WIDTH-1:0] issue,
   output logic [NUM_INSTRUCTIONS*CYCLE_WIDTH-1:0] ex_start,
   output logic [NUM_INSTRUCTIONS*CYCLE_WIDTH-1:0] ex_comp,
   output logic [NUM_INSTRUCTIONS*CYCLE_WIDTH-1:0] write,
   output logic [NUM_INSTRUCTIONS*CYCLE_WIDTH-1:0] commit
);
   localparam int R  = $clog2(NUM_REGISTERS);
   localparam int NI = NUM_INSTRUCTIONS;
   localparam int CW = CYCLE_WIDTH;
   localparam int IW = INSTR_WIDTH;
   localparam int NW = INSTR_WIDTH + 1;

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;
   typedef logic [CW-1:0] cyc_t;

   state_t                       state_q, state_d;
   logic [INSTRUCTION_WIDTH-1:0] prog_q [NI];
   logic [INSTRUCTION_WIDTH-1:0] prog_d [NI];
   cyc_t                         is_q [NI], is_d [NI];
   cyc_t                         es_q [NI], es_d [NI];
   cyc_t                         ec_q [NI], ec_d [NI];
   cyc_t                         wr_q [NI], wr_d [NI];
   cyc_t                         cm_q [NI], cm_d [NI];
   logic [NI-1:0]                s1v_q, s1v_d, s2v_q, s2v_d;
   logic [IW-1:0]                s1t_q [NI], s1t_d [NI];
   logic [IW-1:0]                s2t_q [NI], s2t_d [NI];
   logic [NUM_REGISTERS-1:0]     ratv_q, ratv_d;
   logic [IW-1:0]                ratt_q [NUM_REGISTERS];
   logic [IW-1:0]                ratt_d [NUM_REGISTERS];
   logic [NW-1:0]                n_q, n_d, ip_q, ip_d, cp_q, cp_d;
   cyc_t                         cyc_q, cyc_d;

   logic                         cdb_found;
   logic [NW-1:0]                n_add, n_mul;
   logic [IW-1:0]                hd, ix;
   logic [1:0]                   op;
   logic [R-1:0]                 rd, rs1, rs2;
   logic                         rdy1, rdy2;

   function automatic cyc_t lat_m1(input logic [1:0] o);
      cyc_t l;
      unique case (o)
         2'b00, 2'b01: l = cyc_t'(1);
         2'b10:        l = cyc_t'(9);
         2'b11:        l = cyc_t'(39);
      endcase
      return l;
   endfunction

   always_comb begin
      state_d = state_q;
      prog_d  = prog_q;
      is_d = is_q; es_d = es_q; ec_d = ec_q; wr_d = wr_q; cm_d = cm_q;
      s1v_d = s1v_q; s1t_d = s1t_q; s2v_d = s2v_q; s2t_d = s2t_q;
      ratv_d = ratv_q; ratt_d = ratt_q;
      n_d = n_q; ip_d = ip_q; cp_d = cp_q; cyc_d = cyc_q;
      cdb_found = 1'b0;
      n_add = '0; n_mul = '0;
      hd = cp_q[IW-1:0]; ix = ip_q[IW-1:0];
      op = '0; rd = '0; rs1 = '0; rs2 = '0;
      rdy1 = 1'b0; rdy2 = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            if (load_instruction && n_q < NW'(NI)) begin
               prog_d[n_q[IW-1:0]] = instruction;
               n_d = n_q + NW'(1);
            end
            if (loading_complete) begin
               state_d = (n_d == '0) ? S_DONE : S_RUN;
               cyc_d   = cyc_t'(1);
            end
         end
         S_RUN: begin
            if (cp_q < n_q && wr_q[hd] != '0 && wr_q[hd] < cyc_q) begin
               cm_d[hd] = cyc_q;
               cp_d     = cp_q + NW'(1);
               rd       = prog_q[hd][3*R-1:2*R];
               if (ratv_q[rd] && ratt_q[rd] == hd)
                  ratv_d[rd] = 1'b0;
            end
            // Single CDB: lowest finished index wins, others retry.
            for (int i = 0; i < NI; i++) begin
               if (!cdb_found && es_q[i] != '0 && ec_q[i] < cyc_q &&
                   wr_q[i] == '0) begin
                  wr_d[i]   = cyc_q;
                  cdb_found = 1'b1;
               end
            end
            for (int i = 0; i < NI; i++) begin
               rdy1 = !s1v_q[i] ||
                      (wr_q[s1t_q[i]] != '0 && wr_q[s1t_q[i]] < cyc_q);
               rdy2 = !s2v_q[i] ||
                      (wr_q[s2t_q[i]] != '0 && wr_q[s2t_q[i]] < cyc_q);
               if (is_q[i] != '0 && is_q[i] < cyc_q && es_q[i] == '0 &&
                   rdy1 && rdy2) begin
                  es_d[i] = cyc_q;
                  ec_d[i] = cyc_q + lat_m1(prog_q[i][3*R+1:3*R]);
               end
            end
            // A station stays busy until the cycle after its CDB write.
            for (int i = 0; i < NI; i++) begin
               if (is_q[i] != '0 && wr_q[i] == '0) begin
                  if (prog_q[i][3*R+1]) n_mul = n_mul + NW'(1);
                  else                  n_add = n_add + NW'(1);
               end
            end
            if (ip_q < n_q) begin
               op  = prog_q[ix][3*R+1:3*R];
               rd  = prog_q[ix][3*R-1:2*R];
               rs1 = prog_q[ix][2*R-1:R];
               rs2 = prog_q[ix][R-1:0];
               if (op[1] ? (n_mul < NW'(2)) : (n_add < NW'(3))) begin
                  is_d[ix]   = cyc_q;
                  s1v_d[ix]  = ratv_q[rs1];
                  s1t_d[ix]  = ratt_q[rs1];
                  s2v_d[ix]  = ratv_q[rs2];
                  s2t_d[ix]  = ratt_q[rs2];
                  ratv_d[rd] = 1'b1;
                  ratt_d[rd] = ix;
                  ip_d       = ip_q + NW'(1);
               end
            end
            if (cp_d == n_q || cyc_q == cyc_t'(NUM_CYCLES - 1))
               state_d = S_DONE;
            else
               cyc_d = cyc_q + cyc_t'(1);
         end
         S_DONE: begin
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_LOAD;
         for (int i = 0; i < NI; i++) begin
            prog_q[i] <= '0;
            is_q[i]   <= '0;
            es_q[i]   <= '0;
            ec_q[i]   <= '0;
            wr_q[i]   <= '0;
            cm_q[i]   <= '0;
            s1t_q[i]  <= '0;
            s2t_q[i]  <= '0;
         end
         for (int r = 0; r < NUM_REGISTERS; r++) ratt_q[r] <= '0;
         s1v_q  <= '0;
         s2v_q  <= '0;
         ratv_q <= '0;
         n_q    <= '0;
         ip_q   <= '0;
         cp_q   <= '0;
         cyc_q  <= '0;
      end else begin
         state_q <= state_d;
         prog_q  <= prog_d;
         is_q    <= is_d;
         es_q    <= es_d;
         ec_q    <= ec_d;
         wr_q    <= wr_d;
         cm_q    <= cm_d;
         s1v_q   <= s1v_d;
         s1t_q   <= s1t_d;
         s2v_q   <= s2v_d;
         s2t_q   <= s2t_d;
         ratv_q  <= ratv_d;
         ratt_q  <= ratt_d;
         n_q     <= n_d;
         ip_q    <= ip_d;
         cp_q    <= cp_d;
         cyc_q   <= cyc_d;
      end
   end

   for (genvar g = 0; g < NI; g++) begin : g_flat
      assign issue[g*CW +: CW]    = is_q[g];
      assign ex_start[g*CW +: CW] = es_q[g];
      assign ex_comp[g*CW +: CW]  = ec_q[g];
      assign write[g*CW +: CW]    = wr_q[g];
      assign commit[g*CW +: CW]   = cm_q[g];
   end
endmodule

// File: tb/tb_tomasulo_core.sv
// Scoreboard bench for tomasulo_core: expected event rows are queued at
// load time and compared as each instruction's commit appears.
module tb_tomasulo_core;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] instruction = '0;
   logic        load_instruction = 1'b0;
   logic        loading_complete = 1'b0;
   logic [63:0] issue, ex_start, ex_comp, write, commit;

   tomasulo_core dut (
      .clk              (clk),
      .reset            (reset),
      .instruction      (instruction),
      .load_instruction (load_instruction),
      .loading_complete (loading_complete),
      .issue            (issue),
      .ex_start         (ex_start),
      .ex_comp          (ex_comp),
      .write            (write),
      .commit           (commit)
   );

   always #5 clk = ~clk;

   typedef struct {
      string nm;
      int    idx;
      int    is_c, es_c, ec_c, wr_c, cm_c;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] fld(input logic [63:0] v, input int i);
      return v[i*8 +: 8];
   endfunction

   function automatic logic [10:0] enc(input logic [1:0] op,
         input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, rs2};
   endfunction

   task automatic push(input string nm, input int idx, input int a,
         input int b, input int c, input int d, input int e);
      exp_t x;
      x.nm = nm; x.idx = idx;
      x.is_c = a; x.es_c = b; x.ec_c = c; x.wr_c = d; x.cm_c = e;
      sb.push_back(x);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      load_instruction = 1'b0;
      loading_complete = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic load_w(input logic [10:0] w);
      @(negedge clk);
      instruction = w;
      load_instruction = 1'b1;
      @(negedge clk);
      load_instruction = 1'b0;
   endtask

   task automatic start();
      @(negedge clk);
      loading_complete = 1'b1;
      @(negedge clk);
      loading_complete = 1'b0;
   endtask

   task automatic drain();
      int   budget;
      exp_t x;
      budget = 300;
      while (sb.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
         while (sb.size() > 0 && fld(commit, sb[0].idx) != 0) begin
            x = sb.pop_front();
            check({x.nm, ".issue"},    64'(fld(issue, x.idx)),    64'(x.is_c));
            check({x.nm, ".ex_start"}, 64'(fld(ex_start, x.idx)), 64'(x.es_c));
            check({x.nm, ".ex_comp"},  64'(fld(ex_comp, x.idx)),  64'(x.ec_c));
            check({x.nm, ".write"},    64'(fld(write, x.idx)),    64'(x.wr_c));
            check({x.nm, ".commit"},   64'(fld(commit, x.idx)),   64'(x.cm_c));
         end
      end
      if (sb.size() > 0) check("commit_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".issue"},    issue,    64'd0);
      check({tag, ".ex_start"}, ex_start, 64'd0);
      check({tag, ".ex_comp"},  ex_comp,  64'd0);
      check({tag, ".write"},    write,    64'd0);
      check({tag, ".commit"},   commit,   64'd0);
   endtask

   initial begin
      do_reset();
      check_zero("rst");

      // single ADD, then loads after start must be ignored
      load_w(enc(2'b00, 3'd1, 3'd2, 3'd3));
      push("add1", 0, 1, 2, 3, 4, 5);
      start();
      drain();
      load_w(enc(2'b00, 3'd4, 3'd5, 3'd6));
      start();
      repeat (10) @(negedge clk);
      check("late_load.issue1", 64'(fld(issue, 1)), 64'd0);
      check("late_load.commit0", 64'(fld(commit, 0)), 64'd5);

      // RAW dependency
      do_reset();
      load_w(enc(2'b00, 3'd1, 3'd2, 3'd3));
      load_w(enc(2'b00, 3'd2, 3'd1, 3'd1));
      push("raw0", 0, 1, 2, 3, 4, 5);
      push("raw1", 1, 2, 5, 6, 7, 8);
      start();
      drain();

      // out-of-order completion
      do_reset();
      load_w(enc(2'b10, 3'd1, 3'd2, 3'd3));
      load_w(enc(2'b00, 3'd4, 3'd5, 3'd6));
      push("ooo_mul", 0, 1, 2, 11, 12, 13);
      push("ooo_add", 1, 2, 3, 4, 5, 14);
      start();
      drain();

      // structural stall on add stations
      do_reset();
      for (int i = 0; i < 4; i++)
         load_w(enc(2'b00, 3'(i + 1), 3'd0, 3'd0));
      push("st0", 0, 1, 2, 3, 4, 5);
      push("st1", 1, 2, 3, 4, 5, 6);
      push("st2", 2, 3, 4, 5, 6, 7);
      push("st3", 3, 5, 6, 7, 8, 9);
      start();
      drain();

      // CDB conflict
      do_reset();
      load_w(enc(2'b10, 3'd1, 3'd2, 3'd3));
      load_w(enc(2'b00, 3'd4, 3'd1, 3'd2));
      load_w(enc(2'b01, 3'd6, 3'd1, 3'd3));
      push("cdb_mul", 0, 1, 2, 11, 12, 13);
      push("cdb_add", 1, 2, 13, 14, 15, 16);
      push("cdb_sub", 2, 3, 13, 14, 16, 17);
      start();
      drain();

      // DIV latency
      do_reset();
      load_w(enc(2'b11, 3'd1, 3'd2, 3'd3));
      push("div", 0, 1, 2, 41, 42, 43);
      start();
      drain();

      // empty program
      do_reset();
      start();
      repeat (20) @(negedge clk);
      check_zero("empty");

      // reset mid-run during simulated cycle 6
      do_reset();
      load_w(enc(2'b10, 3'd1, 3'd2, 3'd3));
      start();
      repeat (6) @(posedge clk);
      #2;
      check("midrun.issue0", 64'(fld(issue, 0)), 64'd1);
      check("midrun.ex_start0", 64'(fld(ex_start, 0)), 64'd2);
      reset = 1'b0;
      #1;
      check_zero("midrun_rst");
      @(negedge clk);
      reset = 1'b1;
      load_w(enc(2'b00, 3'd1, 3'd2, 3'd3));
      push("reload", 0, 1, 2, 3, 4, 5);
      start();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tomasulo_core.md
# tomasulo_core

Cycle-accurate Tomasulo/ROB schedule generator. The block loads a short program of register-to-register instructions one word per clock. After loading completes, it simulates out-of-order issue, execution, common-data-bus writeback and in-order commit, advancing one simulated cycle per clock. It exposes per-instruction event-cycle tables as flat output vectors, which the verification environment reads and checks with its assertion and coverage monitors.

## Interface
- NUM_INSTRUCTIONS, 8: program capacity; ROB depth equals this value, so the ROB is never full.
- NUM_REGISTERS, 8: architectural register count; register field width R = log2(NUM_REGISTERS).
- INSTR_WIDTH, 3: instruction-index width, log2(NUM_INSTRUCTIONS).
- NUM_CYCLES, 128: simulated-cycle limit.
- CYCLE_WIDTH, 8: width of each recorded cycle number.
- INSTRUCTION_WIDTH, 11: encoded word width, 2 + 3R.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- instruction  in  INSTRUCTION_WIDTH  word fields: op[10:9], rd[8:6], rs1[5:3], rs2[2:0].
- load_instruction  in  1  when high, stores `instruction` at the next program slot.
- loading_complete  in  1  when high, starts simulation.
- issue, ex_start, ex_comp, write, commit  out  NUM_INSTRUCTIONS*CYCLE_WIDTH each  the entry for instruction i is at [i*CYCLE_WIDTH +: CYCLE_WIDTH]; 0 means the event has not occurred.

## Operation
- Opcodes and latency L: 00 ADD (L=2), 01 SUB (L=2), 10 MUL (L=10), 11 DIV (L=40).
- Reservation stations: 3 add/sub stations and 2 mul/div stations. Each functional unit is unpipelined per station, and stations execute concurrently.
- Load phase:
  - Each load stores the word at load pointer N, then increments N.
  - Loads beyond NUM_INSTRUCTIONS are ignored.
  - Loads after start are ignored.
- Start: loading_complete sampled high causes the block to leave the load phase. The following rising edge is simulated cycle c=1.
- Per simulated cycle c, all actions below are evaluated from state at the start of c:
  - Commit: the ROB head with write<c and write≠0 sets commit=c. At most one commit per cycle, in program order. If the RAT still names that entry, the RAT entry is cleared.
  - CDB: among entries with ex_comp<c and no write yet, the lowest index sets write=c. Only one write per cycle; all others retry in the next cycle. The writing instruction's station frees at the end of c.
  - Execute: an issued entry with issue<c whose operands are ready starts execution, setting ex_start=c, then ex_comp=c+L-1.
    - An operand is ready if it had no producer at issue time, or if the producer's write is below c. A producer writing at cycle w therefore enables consumers to start at w+1.
  - Issue: the next program instruction issues with issue=c if a station of its class is free. Operand producers are captured from the RAT, then RAT[rd] is set to this entry. Issue is strictly in order, at most one per cycle. A structural stall holds all later instructions.
- Simulation ends when all N instructions have committed, or when c reaches NUM_CYCLES. After that the tables hold steady.
- If N=0, all outputs stay 0.

## Timing
- Reset (asynchronous, while reset=0):
  - All output tables become 0.
  - N, the cycle counter, the RAT, the ROB and the stations clear.
  - The block returns to the load phase.
  - Reset asserted mid-simulation discards all progress immediately.
- Load: one word per clock, accepted on the edge where load_instruction=1.
- If load_instruction and loading_complete are high in the same edge, the word is stored first, then the block starts.
- Each table entry is written exactly once, on the edge of its cycle, with value c. Values then hold until reset.
- Invariants per instruction: issue<ex_start, ex_comp=ex_start+L-1, ex_comp<write<commit.
- Cross-instruction invariants:
  - issue and commit are strictly increasing with program index.
  - No two instructions share a write value.
  - A station frees at write and is reusable from write+1.

## Test plan
- Single ADD r1,r2,r3 -> issue=1, ex_start=2, ex_comp=3, write=4, commit=5.
- RAW dependency: ADD r1,r2,r3 followed by ADD r2,r1,r1 -> second instruction: issue=2, ex_start=5, ex_comp=6, write=7, commit=8.
- Out-of-order completion: MUL r1,r2,r3 followed by ADD r4,r5,r6:
  - MUL -> 1/2/11/12/13.
  - ADD -> 2/3/4/5, commit=14.
- Structural stall: four independent ADDs -> ADD0..2 issue 1,2,3. ADD3 issues at 5, with ex_start=6, ex_comp=7, write=8, commit=9.
- CDB conflict: MUL r1,r2,r3; ADD r4,r1,r2; SUB r6,r1,r3 ->
  - MUL write=12.
  - ADD and SUB both ex_comp=14.
  - ADD write=15, SUB write=16.
  - Commits 13, 16, 17.
- Reset mid-run at simulated cycle 6 -> all tables return to 0 immediately. Reloading the single-ADD program then reproduces 1/2/3/4/5.
